// File: rtl/current_dac_ctrl_pkg.sv
// Purpose : shared types and array geometry for the current DAC controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: state_t (controller FSM states), unit-array geometry constants.
package cdac_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // Unit array: 17 thermometer units of 64 LSB each plus a 6-bit binary tail.
  localparam int NUM_THERM   = 17;
  localparam int NUM_BIN     = 6;
  localparam int UNIT_LSB    = 64;
  // Full scale: every thermometer unit plus every binary unit on.
  localparam int CODE_MAX    = NUM_THERM * UNIT_LSB + (UNIT_LSB - 1);
  // Wide enough to hold a thermometer count of 0..NUM_THERM.
  localparam int THERM_CNT_W = $clog2(NUM_THERM + 1);

endpackage

// File: rtl/current_dac_ctrl_if.sv
// Purpose : DAC code valid/ready channel into the current DAC controller.
// Latency : n/a (wires only).
// Backpr. : slave drops code_ready while an update is being held off.
//
// Signals: code (requested DAC code), code_valid, code_ready.
interface current_dac_ctrl_if #(
  parameter int CODE_W = 11
) ();

  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output code,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/current_dac_ctrl_therm_decode.sv
// Purpose : thermometer decoder, count n -> lowest n unit enables set.
// Latency : combinational.
// Backpr. : none.
//
// Ports: count (units to switch on), therm (per-unit enables, [0] fills first).
// Counts above NUM_THERM saturate to all units on.
module cdac_therm_decode
  import cdac_pkg::*;
(
  input  logic [THERM_CNT_W-1:0] count,
  output logic [NUM_THERM-1:0]   therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_THERM; i++) begin
      therm[i] = (count > THERM_CNT_W'(i));
    end
  end

endmodule

// File: rtl/current_dac_ctrl.sv
// Purpose : power-up sequencing, code decode and fault shutdown for the current DAC unit array.
// Latency : enables update 1 cycle after a code transfer; pdb rises 1 cycle after enable.
// Backpr. : code_ready low outside ACTIVE and for UPD_HOLD cycles after each accepted code.
//
// Ports: clk, rst_n (async active-low), enable, supply_ok, code_if (code/code_valid/code_ready),
//        red_sel, atb_sel -> pdb, therm_en, bin_en, bin_red_en, atb_ena, fault, sat.
module current_dac_ctrl
  import cdac_pkg::*;
#(
  parameter int CODE_W        = 11,
  parameter int SETTLE_CYCLES = 64,
  parameter int UPD_HOLD      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 supply_ok,
  current_dac_ctrl_if.slave    code_if,
  input  logic                 red_sel,
  input  logic [1:0]           atb_sel,
  output logic                 pdb,
  output logic [NUM_THERM-1:0] therm_en,
  output logic [NUM_BIN-1:0]   bin_en,
  output logic                 bin_red_en,
  output logic [1:0]           atb_ena,
  output logic                 fault,
  output logic                 sat
);

  localparam int SET_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int HOLD_W    = $clog2(UPD_HOLD + 1);
  localparam int LSB_SHIFT = $clog2(UNIT_LSB);

  state_t              state_q, state_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic                code_ready_int;
  logic                xfer;

  // Decode of the code currently on the bus.
  logic                dec_sat;
  logic [CODE_W-1:0]   codec;
  logic [THERM_CNT_W-1:0] therm_cnt;
  logic [NUM_THERM-1:0]   dec_therm;
  logic [NUM_BIN-1:0]     dec_bin;
  logic                   dec_red;

  // Next values of the registered outputs.
  logic                 pdb_d;
  logic [NUM_THERM-1:0] therm_en_d;
  logic [NUM_BIN-1:0]   bin_en_d;
  logic                 bin_red_en_d;
  logic [1:0]           atb_ena_d;
  logic                 fault_d;
  logic                 sat_d;

  assign code_ready_int     = (state_q == ACTIVE) && (hold_cnt_q == '0);
  assign code_if.code_ready = code_ready_int;
  assign xfer               = code_if.code_valid & code_ready_int;

  // Clamp to full scale; anything above it lights every unit and flags sat.
  assign dec_sat   = code_if.code > CODE_W'(CODE_MAX);
  assign codec     = dec_sat ? CODE_W'(CODE_MAX) : code_if.code;
  assign therm_cnt = THERM_CNT_W'(codec[CODE_W-1:LSB_SHIFT]);

  cdac_therm_decode u_therm_decode (
    .count (therm_cnt),
    .therm (dec_therm)
  );

  // With red_sel the LSB weight moves from bin_en[0] to the redundant unit.
  always_comb begin
    dec_bin = codec[NUM_BIN-1:0];
    dec_red = 1'b0;
    if (red_sel) begin
      dec_bin[0] = 1'b0;
      dec_red    = codec[0];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    hold_cnt_d   = '0;

    unique case (state_q)
      OFF: begin
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        // Dropping enable wins over a supply fault so a deliberate
        // power-down never latches the fault flag.
        if (!enable) begin
          state_d = OFF;
        end else if (!supply_ok) begin
          state_d = FAULT;
        end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ACTIVE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_d = OFF;
        end else if (!supply_ok) begin
          state_d = FAULT;
        end else if (xfer) begin
          hold_cnt_d = HOLD_W'(UPD_HOLD);
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      FAULT: begin
        if (!enable) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    pdb_d        = (state_d == SETTLE) || (state_d == ACTIVE);
    fault_d      = (state_d == FAULT);
    therm_en_d   = '0;
    bin_en_d     = '0;
    bin_red_en_d = 1'b0;
    atb_ena_d    = 2'b00;
    sat_d        = sat;

    // Enables only survive while staying in (or entering) ACTIVE; a
    // transfer in a cycle that leaves ACTIVE is dropped here as well.
    if (state_d == ACTIVE) begin
      atb_ena_d    = atb_sel;
      therm_en_d   = therm_en;
      bin_en_d     = bin_en;
      bin_red_en_d = bin_red_en;
      if (xfer) begin
        therm_en_d   = dec_therm;
        bin_en_d     = dec_bin;
        bin_red_en_d = dec_red;
        sat_d        = dec_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
      pdb          <= 1'b0;
      therm_en     <= '0;
      bin_en       <= '0;
      bin_red_en   <= 1'b0;
      atb_ena      <= 2'b00;
      fault        <= 1'b0;
      sat          <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      pdb          <= pdb_d;
      therm_en     <= therm_en_d;
      bin_en       <= bin_en_d;
      bin_red_en   <= bin_red_en_d;
      atb_ena      <= atb_ena_d;
      fault        <= fault_d;
      sat          <= sat_d;
    end
  end

endmodule
